// File: rtl/mdu_sequencer.sv
// Iterative RV64 M-extension unit: radix-2 shift-add multiply and restoring divide.
// Holds the pipeline via stall while iterating, then pulses done with the result.
module mdu_sequencer #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [2:0] OP_MUL  = 3'b000;
    localparam logic [2:0] OP_DIV  = 3'b001;
    localparam logic [2:0] OP_DIVU = 3'b010;
    localparam logic [2:0] OP_REM  = 3'b011;
    localparam logic [2:0] OP_REMU = 3'b100;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic            word_q, neg_q, neg_r;
    logic [XLEN-1:0] acc_q, sh_q, opd_q;

    function automatic logic [XLEN-1:0] fix_word(input logic w, input logic [XLEN-1:0] v);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    // Operand decode on the execute-stage inputs, used only on the accept edge.
    logic            sext_in, div_signed, is_div, illegal, div_zero, overflow, special;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] ax, bx, a_mag, b_mag, min_val, special_res;

    always_comb begin
        sext_in    = (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
        div_signed = (op == OP_DIV) || (op == OP_REM);
        is_div     = (op != OP_MUL) && (op <= OP_REMU);
        illegal    = (op > OP_REMU);
        ax = a;
        bx = b;
        if (word) begin
            ax = {{(XLEN-32){sext_in & a[31]}}, a[31:0]};
            bx = {{(XLEN-32){sext_in & b[31]}}, b[31:0]};
        end
        a_neg   = div_signed && ax[XLEN-1];
        b_neg   = div_signed && bx[XLEN-1];
        a_mag   = a_neg ? -ax : ax;
        b_mag   = b_neg ? -bx : bx;
        min_val = word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (bx == '0);
        overflow = div_signed && (ax == min_val) && (bx == '1);
        special  = illegal || (is_div && (div_zero || overflow));

        special_res = '0;
        if (!illegal) begin
            if (div_zero)
                special_res = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : ax;
            else if (overflow)
                special_res = (op == OP_DIV) ? ax : '0;
        end
    end

    // One iteration step: the same three registers serve both algorithms.
    logic [XLEN:0]   trial;
    logic            ge;
    logic [XLEN-1:0] acc_sub, acc_n, sh_n, opd_n, raw, calc_res;
    logic [CW-1:0]   last_cnt;

    always_comb begin
        trial   = {acc_q, sh_q[XLEN-1]};
        ge      = trial >= {1'b0, opd_q};
        acc_sub = trial[XLEN-1:0] - opd_q;
        if (op_q == OP_MUL) begin
            acc_n = acc_q + (sh_q[0] ? opd_q : '0);
            sh_n  = sh_q >> 1;
            opd_n = opd_q << 1;
        end else begin
            acc_n = ge ? acc_sub : trial[XLEN-1:0];
            sh_n  = {sh_q[XLEN-2:0], ge};
            opd_n = opd_q;
        end
        case (op_q)
            OP_MUL:          raw = acc_n;
            OP_DIV, OP_DIVU: raw = neg_q ? -sh_n : sh_n;
            default:         raw = neg_r ? -acc_n : acc_n;
        endcase
        calc_res = fix_word(word_q, raw);
        last_cnt = word_q ? CW'(31) : CW'(XLEN-1);
    end

    assign stall = valid && (state != DONE) && !reset;

    // NOTE: the datapath registers are reset too; they are few and this keeps
    // simulation free of X propagation through the iteration logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            word_q <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc_q  <= '0;
            sh_q   <= '0;
            opd_q  <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid && !flush) begin
                        op_q   <= op;
                        word_q <= word;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        cnt    <= '0;
                        acc_q  <= '0;
                        if (op == OP_MUL) begin
                            sh_q  <= bx;
                            opd_q <= ax;
                        end else begin
                            sh_q  <= word ? (a_mag << (XLEN-32)) : a_mag;
                            opd_q <= b_mag;
                        end
                        if (special) begin
                            state  <= DONE;
                            result <= fix_word(word, special_res);
                            done   <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc_q <= acc_n;
                        sh_q  <= sh_n;
                        opd_q <= opd_n;
                        cnt   <= cnt + 1'b1;
                        if (cnt == last_cnt) begin
                            state  <= DONE;
                            result <= calc_res;
                            done   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed vectors plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_mdu_sequencer;
    logic        clk = 1'b0;
    logic        reset, valid, word, flush;
    logic [2:0]  op;
    logic [63:0] a, b;
    logic        stall, done;
    logic [63:0] result;

    int checks = 0;
    int failures = 0;
    logic [63:0] last_res = '0;

    mdu_sequencer #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .valid(valid), .op(op), .word(word),
        .a(a), .b(b), .flush(flush), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    function automatic logic [63:0] ext_op(input logic [2:0] o, input logic w, input logic [63:0] v);
        if (!w) return v;
        if (o == 3'd2 || o == 3'd4) return {32'b0, v[31:0]};
        return sx32(v);
    endfunction

    function automatic logic is_ovf(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y);
        logic [63:0] mn;
        mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        return (o == 3'd1 || o == 3'd3) && x == mn && y == '1;
    endfunction

    function automatic logic [63:0] model(input logic [2:0] o, input logic w, input logic [63:0] ai, input logic [63:0] bi);
        logic [63:0] x, y, r;
        logic signed [63:0] sa, sb, sr;
        x = ext_op(o, w, ai);
        y = ext_op(o, w, bi);
        sa = x;
        sb = y;
        r = '0;
        case (o)
            3'd0: r = x * y;
            3'd1: if (y == 0) r = '1;
                  else if (is_ovf(o, w, x, y)) r = x;
                  else begin sr = sa / sb; r = sr; end
            3'd2: r = (y == 0) ? '1 : x / y;
            3'd3: if (y == 0) r = x;
                  else if (is_ovf(o, w, x, y)) r = '0;
                  else begin sr = sa % sb; r = sr; end
            3'd4: r = (y == 0) ? x : x % y;
            default: r = '0;
        endcase
        return w ? sx32(r) : r;
    endfunction

    function automatic int model_stall(input logic [2:0] o, input logic w, input logic [63:0] ai, input logic [63:0] bi);
        logic [63:0] x, y;
        x = ext_op(o, w, ai);
        y = ext_op(o, w, bi);
        if (o > 3'd4) return 1;
        if (o != 3'd0 && (y == 0 || is_ovf(o, w, x, y))) return 1;
        return w ? 33 : 65;
    endfunction

    // Issue one op and watch it cycle by cycle; operands are scrambled after acceptance.
    task automatic run_op(input string name, input logic [2:0] o, input logic w,
                          input logic [63:0] ai, input logic [63:0] bi,
                          input logic [63:0] exp_res, input int exp_stall,
                          input logic hold, input logic no_wait);
        int n = 0;
        logic seen = 1'b0;
        if (!no_wait) @(negedge clk);
        valid = 1'b1; op = o; word = w; a = ai; b = bi;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
            end
            #1;
            if (done) begin seen = 1'b1; break; end
            check({name, "_stall_hi"}, {63'b0, stall}, 64'd1);
            check({name, "_held"}, result, last_res);
            n++;
        end
        check({name, "_done_seen"}, {63'b0, seen}, 64'd1);
        check({name, "_stall_cycles"}, 64'(n), 64'(exp_stall));
        check({name, "_stall_in_done"}, {63'b0, stall}, 64'd0);
        check({name, "_result"}, result, exp_res);
        last_res = exp_res;
        if (!hold) valid = 1'b0;
    endtask

    task automatic run_rand(input string name, input logic [2:0] o, input logic w,
                            input logic [63:0] ai, input logic [63:0] bi);
        run_op(name, o, w, ai, bi, model(o, w, ai, bi), model_stall(o, w, ai, bi), 1'b0, 1'b0);
    endtask

    initial begin
        int done_cnt;
        logic [2:0]  ro;
        logic        rw;
        logic [63:0] ra, rb;

        // Pin the model itself against hand-computed values.
        check("model_divu", model(3'd2, 0, 100, 7), 64'd14);
        check("model_remu", model(3'd4, 0, 100, 7), 64'd2);
        check("model_div_neg", model(3'd1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 2), 64'hFFFF_FFFF_FFFF_FFFD);
        check("model_rem_neg", model(3'd3, 0, 64'hFFFF_FFFF_FFFF_FFF9, 2), 64'hFFFF_FFFF_FFFF_FFFF);
        check("model_divw_ovf", model(3'd1, 1, 64'h8000_0000, 64'hFFFF_FFFF), 64'hFFFF_FFFF_8000_0000);
        check("model_mulw", model(3'd0, 1, 64'h1_0000, 64'h1_0000), 64'd0);

        // Reset state, with valid high to show stall is forced low.
        reset = 1'b1; valid = 1'b1; op = '0; word = 1'b0; a = '0; b = '0; flush = 1'b0;
        #1;
        check("reset_stall", {63'b0, stall}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_result", result, 64'd0);
        @(negedge clk); valid = 1'b0;
        @(negedge clk); reset = 1'b0;

        // Directed vectors.
        run_op("divu", 3'd2, 0, 100, 7, 64'd14, 65, 1'b0, 1'b0);
        run_op("remu", 3'd4, 0, 100, 7, 64'd2, 65, 1'b0, 1'b0);
        run_op("div_neg", 3'd1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0, 1'b0);
        run_op("rem_neg", 3'd3, 0, 64'hFFFF_FFFF_FFFF_FFF9, 2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0, 1'b0);
        run_op("divu_zero", 3'd2, 0, 5, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0, 1'b0);
        run_op("remu_zero", 3'd4, 0, 5, 0, 64'd5, 1, 1'b0, 1'b0);
        run_op("divw_ovf", 3'd1, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 1'b0, 1'b0);
        run_op("mulw", 3'd0, 1, 64'h1_0000, 64'h1_0000, 64'd0, 33, 1'b0, 1'b0);
        run_op("mul", 3'd0, 0, 64'h1_0000, 64'h1_0000, 64'h1_0000_0000, 65, 1'b0, 1'b0);
        run_op("illegal", 3'd6, 0, 64'd9, 64'd3, 64'd0, 1, 1'b0, 1'b0);

        // Back-to-back: valid stays high through DONE, next op accepted right after.
        run_op("b2b_first", 3'd2, 1, 64'd1000, 64'd9, 64'd111, 33, 1'b1, 1'b0);
        run_op("b2b_second", 3'd4, 1, 64'd1000, 64'd9, 64'd1, 33, 1'b0, 1'b0);

        // Flush in CALC cycle 10: no done, result held, next op starts clean.
        @(negedge clk); valid = 1'b1; op = 3'd2; word = 1'b0; a = 64'd500; b = 64'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        #1;
        check("flush_no_done", {63'b0, done}, 64'd0);
        check("flush_result_held", result, last_res);
        run_op("after_flush", 3'd4, 0, 64'd500, 64'd3, 64'd2, 65, 1'b0, 1'b1);

        // Flush has priority over valid in IDLE.
        @(negedge clk); valid = 1'b1; flush = 1'b1; op = 3'd2; a = 64'd50; b = 64'd5;
        @(negedge clk); valid = 1'b0; flush = 1'b0;
        done_cnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("idle_flush_no_done", 64'(done_cnt), 64'd0);

        // Reset mid-CALC, then an op offered in the same cycle reset drops.
        @(negedge clk); valid = 1'b1; op = 3'd1; word = 1'b0; a = 64'd77; b = 64'd4;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_stall", {63'b0, stall}, 64'd0);
        check("midreset_result", result, 64'd0);
        check("midreset_done", {63'b0, done}, 64'd0);
        last_res = '0;
        @(negedge clk); reset = 1'b0;
        run_op("after_reset", 3'd1, 0, 64'd77, 64'd4, 64'd19, 65, 1'b0, 1'b1);

        // Randomized ops drawn from a mix of operand classes.
        for (int i = 0; i < 40; i++) begin
            ro = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            rw = 1'($urandom_range(0, 1));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: begin ra = rw ? 64'h8000_0000 : 64'h8000_0000_0000_0000; rb = '1; end
                2: begin ra = 64'($urandom_range(0, 1000)); rb = 64'($urandom_range(1, 20)); end
                3: begin ra = -64'($urandom_range(1, 1000)); rb = 64'($urandom_range(1, 20)); end
                4: rb = -64'($urandom_range(1, 50));
                default: ;
            endcase
            run_rand($sformatf("rand%0d", i), ro, rw, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have parameter: XLEN, 64, operand/result width (word ops always use the low 32 bits).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: valid  input  1  execute stage currently holds a mul/div instruction.
REQ-005 SHALL have port: op  input  3  000 MUL, 001 DIV, 010 DIVU, 011 REM, 100 REMU.
REQ-006 SHALL have port: word  input  1  RV64 W-variant (MULW/DIVW/...).
REQ-007 SHALL have port: a  input  XLEN  operand rs1, post-forwarding.
REQ-008 SHALL have port: b  input  XLEN  operand rs2, post-forwarding.
REQ-009 SHALL have port: flush  input  1  abort current op (branch/trap flush of execute).
REQ-010 SHALL have port: stall  output  1  freeze fetch/decode/execute pipeline registers.
REQ-011 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-012 SHALL have port: result  output  XLEN  computed value, held until next done.

Function
REQ-013 SHALL implement states IDLE, CALC, DONE.
REQ-014 IDLE + valid + !flush SHALL latch operands, clear iteration counter, and go to CALC; special cases (REQ-020, REQ-021) go to DONE instead.
REQ-015 CALC SHALL perform one radix-2 iteration per cycle (shift-subtract divide, shift-add multiply), 64 iterations (32 if word), then go to DONE.
REQ-016 DONE SHALL assert done and update result, then go to IDLE unconditionally; valid in DONE SHALL NOT restart.
REQ-017 stall SHALL equal valid && state != DONE (combinational), forced 0 while reset asserted.
REQ-018 Latency: normal op stalls 65 cycles (33 word) and done in the following cycle; special cases stall 1 cycle.
REQ-019 Signed DIV/REM SHALL divide magnitudes, then negate the quotient if operand signs differ and give the remainder the sign of the dividend.
REQ-020 Divide by zero: quotient all ones, remainder = dividend (after word sign-extension).
REQ-021 Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
REQ-022 Word ops SHALL sign-extend (DIV/REM/MUL) or zero-extend (DIVU/REMU) the low 32 operand bits, and the result SHALL be the low 32 bits sign-extended to 64.
REQ-023 MUL SHALL return the low XLEN bits of the product, independent of operand signedness.
REQ-024 flush SHALL return any state to IDLE at the next edge, suppress done, leave result unchanged, and take priority over valid in IDLE.
REQ-025 Illegal op codes (101-111) SHALL go to DONE in one cycle with result 0.
REQ-026 Operands SHALL be sampled only on the IDLE->CALC/DONE edge; changes on a/b afterwards SHALL be ignored.

Reset
REQ-027 Reset assertion SHALL immediately force state IDLE, counter 0, result 0, done 0, stall 0, aborting any op in progress.
REQ-028 After reset deassertion, the first valid SHALL be accepted on the next rising edge.

Verification
REQ-029 DIVU a=100 b=7 word=0 -> stall high 65 cycles, done pulse, result 14; REMU same operands -> 2.
REQ-030 DIV a=0xFFFF_FFFF_FFFF_FFF9 b=2 -> result 0xFFFF_FFFF_FFFF_FFFD; REM -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-031 DIVU a=5 b=0 -> stall 1 cycle, result 0xFFFF_FFFF_FFFF_FFFF; REMU -> 5.
REQ-032 DIV word=1 a=0x8000_0000 b=0xFFFF_FFFF -> stall 1 cycle, result 0xFFFF_FFFF_8000_0000.
REQ-033 MUL a=b=0x1_0000: word=1 -> 0 after 33 stall cycles; word=0 -> 0x1_0000_0000 after 65 stall cycles.
REQ-034 Flush in CALC cycle 10 -> IDLE next cycle, no done pulse. Reset mid-CALC -> stall 0 immediately, result 0. Back-to-back valid after DONE -> new op accepted next cycle.
